// File: rtl/sim_says_checker.sv
// rtl/sim_says_checker.sv - Simon Says sequence store, LED playback and button checker
// Grows a one-hot sequence one entry per round, replays it, then verifies presses.
module sim_says_checker #(
    parameter int MAX_LEN     = 8,
    parameter int WIN_LEN     = 5,
    parameter int SHOW_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 12_500_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [3:0]                   pattern,
    input  logic [3:0]                   btn,
    output logic [3:0]                   led,
    output logic [$clog2(MAX_LEN+1)-1:0] round,
    output logic                         busy,
    output logic                         solved,
    output logic                         fail
);
    localparam int RW   = $clog2(MAX_LEN + 1);
    localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] WIN_ROUND = RW'(WIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_SOLVED, S_FAIL
    } state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n, idx_inc;
    logic [TW-1:0] timer, timer_n;
    logic [RW-1:0] round_n;
    logic [3:0]    led_n;
    logic [3:0]    seq [MAX_LEN];
    logic [3:0]    add_val;
    logic          seq_we;
    logic          last_entry;

    // Anything that is not exactly one bit set is replaced by button 0.
    assign add_val    = (pattern != 4'b0 && (pattern & (pattern - 4'd1)) == 4'b0)
                        ? pattern : 4'b0001;
    assign idx_inc    = idx + 1'b1;
    assign last_entry = (RW'(idx) == round - 1'b1);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        timer_n = timer;
        round_n = round;
        led_n   = led;
        seq_we  = 1'b0;
        if (start) begin
            state_n = S_ADD;
            idx_n   = '0;
            timer_n = '0;
            round_n = '0;
            led_n   = 4'b0;
        end else begin
            case (state)
                S_ADD: begin
                    seq_we  = 1'b1;
                    round_n = round + 1'b1;
                    idx_n   = '0;
                    timer_n = '0;
                    // seq[0] is being written this cycle when the sequence is empty
                    led_n   = (round == '0) ? add_val : seq[0];
                    state_n = S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (timer == SHOW_LAST) begin
                        timer_n = '0;
                        led_n   = 4'b0;
                        state_n = S_SHOW_OFF;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                S_SHOW_OFF: begin
                    if (timer == GAP_LAST) begin
                        timer_n = '0;
                        if (last_entry) begin
                            idx_n   = '0;
                            state_n = S_WAIT_IN;
                        end else begin
                            idx_n   = idx_inc;
                            led_n   = seq[idx_inc];
                            state_n = S_SHOW_ON;
                        end
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                S_WAIT_IN: begin
                    if (btn != 4'b0) begin
                        if (btn == seq[idx]) begin
                            if (last_entry) begin
                                state_n = (round == WIN_ROUND) ? S_SOLVED : S_ADD;
                            end else begin
                                idx_n = idx_inc;
                            end
                        end else begin
                            state_n = S_FAIL;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            timer  <= '0;
            round  <= '0;
            led    <= 4'b0;
            busy   <= 1'b0;
            solved <= 1'b0;
            fail   <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            timer  <= timer_n;
            round  <= round_n;
            led    <= led_n;
            busy   <= (state_n == S_ADD) || (state_n == S_SHOW_ON) ||
                      (state_n == S_SHOW_OFF) || (state_n == S_WAIT_IN);
            solved <= (state_n == S_SOLVED);
            fail   <= (state_n == S_FAIL);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && seq_we) begin
            seq[round[IW-1:0]] <= add_val;
        end
    end

endmodule

// File: tb/tb_sim_says_checker.sv
// tb/tb_sim_says_checker.sv - randomized self-checking bench for sim_says_checker
module tb_sim_says_checker;
    localparam int MAX_LEN = 8;
    localparam int WIN_LEN = 3;
    localparam int SHOW    = 4;
    localparam int GAP     = 2;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] pattern, btn, led;
    logic [3:0] round;
    logic       busy, solved, fail;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_seq[$];

    sim_says_checker #(
        .MAX_LEN(MAX_LEN), .WIN_LEN(WIN_LEN), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .btn(btn),
        .led(led), .round(round), .busy(busy), .solved(solved), .fail(fail)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] norm(input logic [3:0] p);
        return ($countones(p) == 1) ? p : 4'b0001;
    endfunction

    function automatic logic [3:0] rand_onehot();
        return 4'b0001 << $urandom_range(0, 3);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        pattern = 4'($urandom);
    endtask

    task automatic add_round(input logic [3:0] p);
        pattern = p;
        step();
        exp_seq.push_back(norm(p));
    endtask

    task automatic begin_game(input logic [3:0] p);
        btn   = 4'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        exp_seq.delete();
        add_round(p);
    endtask

    task automatic watch_playback(input bit noise, output int bad);
        bad = 0;
        if (round !== 4'(exp_seq.size())) bad++;
        foreach (exp_seq[k]) begin
            for (int c = 0; c < SHOW; c++) begin
                if (led !== exp_seq[k] || busy !== 1'b1) bad++;
                btn = noise ? 4'($urandom) : 4'b0;
                step();
            end
            for (int c = 0; c < GAP; c++) begin
                if (led !== 4'b0 || busy !== 1'b1) bad++;
                btn = noise ? 4'($urandom) : 4'b0;
                step();
            end
        end
        btn = 4'b0;
    endtask

    task automatic answer_all(output int bad);
        bad = 0;
        foreach (exp_seq[k]) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                if (busy !== 1'b1 || fail !== 1'b0 || led !== 4'b0) bad++;
            end
            btn = exp_seq[k];
            step();
            btn = 4'b0;
            if (k < exp_seq.size() - 1 && (busy !== 1'b1 || fail !== 1'b0 || solved !== 1'b0)) bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; btn = 4'b0; pattern = 4'b0;
        repeat (3) step();
        rst = 1'b0;
        n_checks++;
        if ({led, round, busy, solved, fail} !== 11'h0) begin
            n_fail++; $display("FAIL reset_state: got %h expected 000", {led, round, busy, solved, fail});
        end
        btn = 4'b0001; step(); btn = 4'b0; step();
        n_checks++;
        if ({busy, fail, solved} !== 3'b000) begin
            n_fail++; $display("FAIL idle_btn: got %b expected 000", {busy, fail, solved});
        end
        begin_game(4'b1000);
        step(); step();
        n_checks++;
        if (led !== 4'b1000) begin
            n_fail++; $display("FAIL pre_reset_led: got %b expected 1000", led);
        end
        rst = 1'b1; step(); rst = 1'b0;
        n_checks++;
        if ({led, round, busy, solved, fail} !== 11'h0) begin
            n_fail++; $display("FAIL mid_show_reset: got %h expected 000", {led, round, busy, solved, fail});
        end
    endtask

    task automatic test_first_round();
        int bad;
        begin_game(4'b0100);
        n_checks++;
        if (round !== 4'd1 || busy !== 1'b1 || led !== 4'b0100) begin
            n_fail++; $display("FAIL first_show: got round=%0d busy=%b led=%b expected 1 1 0100", round, busy, led);
        end
        watch_playback(1'b0, bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL first_playback: got %0d bad cycles expected 0", bad);
        end
        answer_all(bad);
        n_checks++;
        if (bad !== 0 || round !== 4'd1 || busy !== 1'b1 || solved !== 1'b0) begin
            n_fail++; $display("FAIL first_answer: got bad=%0d round=%0d busy=%b expected 0 1 1", bad, round, busy);
        end
        add_round(4'b0001);
        n_checks++;
        if (round !== 4'd2) begin
            n_fail++; $display("FAIL second_round: got %0d expected 2", round);
        end
    endtask

    task automatic test_full_game(input logic [3:0] p0, input logic [3:0] p1, input logic [3:0] p2);
        logic [3:0] pats[3];
        int bad;
        pats[0] = p0; pats[1] = p1; pats[2] = p2;
        begin_game(pats[0]);
        for (int r = 0; r < WIN_LEN; r++) begin
            if (r > 0) add_round(pats[r]);
            watch_playback(1'b0, bad);
            n_checks++;
            if (bad !== 0) begin
                n_fail++; $display("FAIL game_playback r%0d: got %0d bad cycles expected 0", r, bad);
            end
            answer_all(bad);
            n_checks++;
            if (bad !== 0) begin
                n_fail++; $display("FAIL game_answer r%0d: got %0d bad cycles expected 0", r, bad);
            end
        end
        n_checks++;
        if ({solved, busy, fail, round, led} !== {3'b100, 4'd3, 4'b0}) begin
            n_fail++; $display("FAIL solved_state: got s=%b b=%b f=%b r=%0d expected 1 0 0 3", solved, busy, fail, round);
        end
        repeat (6) begin btn = 4'($urandom); step(); end
        btn = 4'b0;
        n_checks++;
        if ({solved, busy, fail, round} !== {3'b100, 4'd3}) begin
            n_fail++; $display("FAIL solved_hold: got s=%b b=%b f=%b r=%0d expected 1 0 0 3", solved, busy, fail, round);
        end
    endtask

    task automatic test_wrong_press();
        int bad;
        logic [3:0] p;
        begin_game(4'b0100);
        watch_playback(1'b0, bad);
        answer_all(bad);
        add_round(4'b0001);
        watch_playback(1'b0, bad);
        btn = 4'b0100; step(); btn = 4'b0;
        n_checks++;
        if (fail !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL good_first_press: got fail=%b busy=%b expected 0 1", fail, busy);
        end
        btn = 4'b0010; step(); btn = 4'b0;
        n_checks++;
        if (fail !== 1'b1 || busy !== 1'b0 || solved !== 1'b0) begin
            n_fail++; $display("FAIL wrong_press: got fail=%b busy=%b expected 1 0", fail, busy);
        end
        repeat (4) begin btn = 4'($urandom); step(); end
        btn = 4'b0;
        n_checks++;
        if (fail !== 1'b1) begin
            n_fail++; $display("FAIL fail_hold: got %b expected 1", fail);
        end
        start = 1'b1; step(); start = 1'b0;
        n_checks++;
        if (fail !== 1'b0 || round !== 4'd0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL restart_clear: got fail=%b round=%0d busy=%b expected 0 0 1", fail, round, busy);
        end
        p = rand_onehot();
        exp_seq.delete();
        add_round(p);
        n_checks++;
        if (round !== 4'd1 || led !== p) begin
            n_fail++; $display("FAIL restart_round: got round=%0d led=%b expected 1 %b", round, led, p);
        end
    endtask

    task automatic test_multi_bit_and_noise();
        int bad;
        begin_game(rand_onehot());
        watch_playback(1'b1, bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL noisy_playback: got %0d bad cycles expected 0", bad);
        end
        btn = 4'b0011; step(); btn = 4'b0;
        n_checks++;
        if (fail !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL multi_bit: got fail=%b busy=%b expected 1 0", fail, busy);
        end
    endtask

    task automatic test_bad_pattern_and_start_btn();
        int bad;
        begin_game(4'b0000);
        n_checks++;
        if (led !== 4'b0001) begin
            n_fail++; $display("FAIL zero_pattern: got %b expected 0001", led);
        end
        watch_playback(1'b0, bad);
        answer_all(bad);
        add_round(4'b0110);
        watch_playback(1'b0, bad);
        n_checks++;
        if (bad !== 0 || exp_seq[1] !== 4'b0001) begin
            n_fail++; $display("FAIL two_bit_pattern: got %0d bad cycles expected 0", bad);
        end
        start = 1'b1; btn = exp_seq[0]; step(); start = 1'b0; btn = 4'b0;
        n_checks++;
        if ({round, busy, fail, solved, led} !== {4'd0, 3'b100, 4'b0}) begin
            n_fail++; $display("FAIL start_btn: got r=%0d b=%b f=%b s=%b expected 0 1 0 0", round, busy, fail, solved);
        end
        exp_seq.delete();
        add_round(4'b0010);
        n_checks++;
        if (round !== 4'd1 || led !== 4'b0010) begin
            n_fail++; $display("FAIL start_btn_add: got round=%0d led=%b expected 1 0010", round, led);
        end
    endtask

    task automatic test_random_games();
        int bad;
        bit failed;
        logic [3:0] b;
        for (int g = 0; g < 8; g++) begin
            failed = 1'b0;
            begin_game(4'($urandom));
            for (int r = 0; r < WIN_LEN && !failed; r++) begin
                if (r > 0) add_round(4'($urandom));
                watch_playback(1'($urandom), bad);
                n_checks++;
                if (bad !== 0) begin
                    n_fail++; $display("FAIL rand_playback g%0d r%0d: got %0d bad expected 0", g, r, bad);
                end
                for (int k = 0; k < exp_seq.size() && !failed; k++) begin
                    b = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : exp_seq[k];
                    btn = b; step(); btn = 4'b0;
                    if (b !== exp_seq[k]) failed = 1'b1;
                end
            end
            n_checks++;
            if ({fail, solved, busy} !== {failed, !failed, 1'b0}) begin
                n_fail++; $display("FAIL rand_outcome g%0d: got f=%b s=%b b=%b expected %b %b 0",
                                   g, fail, solved, busy, failed, !failed);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_full_game(4'b0100, 4'b0001, 4'b1000);
        test_full_game(rand_onehot(), rand_onehot(), rand_onehot());
        test_wrong_press();
        test_multi_bit_and_noise();
        test_bad_pattern_and_start_btn();
        test_random_games();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
